prbs7_checker: RTL

Serial PRBS-7 checker (polynomial x^7+x^6+1) on the loopback receive side of the PRBS/LED test path.
- Self-synchronises to the incoming bit stream.
- Declares lock, then counts bit errors.
- Drives two front-panel LEDs: lock, and a pulse-stretched error indication.
- The same polynomial and bit ordering are used by the transmit-side generator, so a clean loopback shows zero errors.

---
 rtl/prbs7_pkg.sv | 22 ++
 rtl/prbs7_checker_led_stretch.sv | 35 +++
 rtl/prbs7_checker.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/prbs7_pkg.sv
// Shared PRBS-7 constants (x^7+x^6+1) for the loopback test path.
// Used by both the transmit generator and the receive checker.
package prbs7_pkg;

  localparam int PRBS_W       = 7;
  localparam int TAP_A        = 6;
  localparam int TAP_B        = 5;
  localparam int LED_HOLD_DEF = 1000;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic prbs7_pred(
    input logic [PRBS_W-1:0] r
  );
    return r[TAP_A] ^ r[TAP_B];
  endfunction

endpackage

// File: rtl/prbs7_checker_led_stretch.sv
// Retriggerable down-counter that stretches single-cycle
// error pulses into a visible front-panel LED indication.
module led_stretch #(
  parameter int LED_HOLD = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic led
);

  localparam int W = $clog2(LED_HOLD + 1);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_n;

  always_comb begin
    cnt_n = cnt;
    if (trig)
      cnt_n = W'(LED_HOLD);
    else if (cnt != '0)
      cnt_n = cnt - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      led <= 1'b0;
    end else begin
      cnt <= cnt_n;
      led <= (cnt_n != '0);
    end
  end

endmodule

// File: rtl/prbs7_checker.sv
// Self-synchronising PRBS-7 receive checker with lock detect,
// saturating error counter and front-panel LED drive.
module prbs7_checker
  import prbs7_pkg::*;
#(
  parameter int LOCK_CNT    = 16,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 16,
  parameter int LED_HOLD    = LED_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_vld,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic             led_lock,
  output logic             led_err
);

  state_t state;
  state_t state_n;

  logic [PRBS_W-1:0] r;
  logic [2:0]        seed_cnt;
  logic [7:0]        good_cnt;
  logic [3:0]        bad_cnt;
  logic              pred;
  logic              match;
  logic              zero;
  logic              err;

  assign pred  = prbs7_pred(r);
  assign match = (din == pred);
  assign zero  = (r == '0);

  always_ff @(posedge clk) begin
    if (rst)
      state <= SEED;
    else
      state <= state_n;
  end

  // An all-zero register would match all-zero input forever.
  always_comb begin
    state_n = state;
    if (din_vld) begin
      unique case (state)
        SEED:
          if (seed_cnt == 3'(PRBS_W - 1))
            state_n = CHECK;
        CHECK:
          if (zero || !match)
            state_n = SEED;
          else if (good_cnt == 8'(LOCK_CNT - 1))
            state_n = LOCKED;
        LOCKED:
          if (!match && bad_cnt == 4'(UNLOCK_ERRS - 1))
            state_n = SEED;
        default:
          state_n = SEED;
      endcase
    end
  end

  always_comb begin
    err = 1'b0;
    if (din_vld && state == LOCKED)
      err = !match;
  end

  // Once locked the register free-runs on its own prediction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r        <= '0;
      seed_cnt <= '0;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (din_vld) begin
      unique case (state)
        SEED: begin
          r        <= {r[PRBS_W-2:0], din};
          good_cnt <= '0;
          if (state_n == CHECK)
            seed_cnt <= '0;
          else
            seed_cnt <= seed_cnt + 3'd1;
        end
        CHECK: begin
          bad_cnt <= '0;
          if (state_n == SEED) begin
            seed_cnt <= '0;
          end else begin
            r        <= {r[PRBS_W-2:0], din};
            good_cnt <= good_cnt + 8'd1;
          end
        end
        LOCKED: begin
          r        <= {r[PRBS_W-2:0], pred};
          seed_cnt <= '0;
          if (match)
            bad_cnt <= '0;
          else
            bad_cnt <= bad_cnt + 4'd1;
        end
        default: begin
          seed_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      led_lock  <= 1'b0;
    end else begin
      locked    <= (state_n == LOCKED);
      err_pulse <= err;
      led_lock  <= locked;
      if (err_clr)
        err_cnt <= CNT_W'(err);
      else if (err && err_cnt != '1)
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  led_stretch #(
    .LED_HOLD (LED_HOLD)
  ) u_led (
    .clk  (clk),
    .rst  (rst),
    .trig (err_pulse),
    .led  (led_err)
  );

endmodule
